// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32 subset core.
// Sequences ALU sources, memory port, IR/PC writes and immediate select per phase; counts retires.
module multicycle_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_src_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             reg_we_o,
  output logic             wb_sel_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       imm_sel_o,
  output logic [2:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_SUB     = 2'd1;
  localparam logic [1:0] ALU_FUNCT   = 2'd2;
  localparam logic [1:0] IMM_I       = 2'd0;
  localparam logic [1:0] IMM_S       = 2'd1;
  localparam logic [1:0] IMM_B       = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [6:0]        opcode;
  logic              op_legal;
  logic              wait_limit;
  logic              instr_unused;

  assign opcode       = instr_i[6:0];
  assign instr_unused = ^instr_i[31:7];
  assign wait_limit   = (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));
  assign op_legal     = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                        (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // State, wait counter and retire counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state and per-phase control decode
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    ret_d       = ret_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_src_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 1'b0;
    reg_we_o    = 1'b0;
    wb_sel_o    = 1'b0;
    alu_src_a_o = SRC_A_PC;
    alu_src_b_o = SRC_B_RS2;
    alu_op_o    = ALU_ADD;
    imm_sel_o   = IMM_I;
    err_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_a_o = SRC_A_PC;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_ADD;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (wait_limit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      // Branch target precomputed into ALUOut while the opcode is checked
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_ADD;
        imm_sel_o   = IMM_B;
        state_d     = op_legal ? S_EXEC : S_ERR;
      end

      S_EXEC: begin
        alu_src_a_o = SRC_A_RS1;
        case (opcode)
          OP_R: begin
            alu_src_b_o = SRC_B_RS2;
            alu_op_o    = ALU_FUNCT;
            state_d     = S_WB;
          end
          OP_I: begin
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = ALU_FUNCT;
            imm_sel_o   = IMM_I;
            state_d     = S_WB;
          end
          OP_LOAD: begin
            alu_src_b_o = SRC_B_IMM;
            imm_sel_o   = IMM_I;
            state_d     = S_MEM;
          end
          OP_STORE: begin
            alu_src_b_o = SRC_B_IMM;
            imm_sel_o   = IMM_S;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_b_o = SRC_B_RS2;
            alu_op_o    = ALU_SUB;
            pc_we_o     = zero_i;
            pc_src_o    = zero_i;
            state_d     = S_FETCH;
            ret_d       = ret_q + CNT_W'(1);
          end
          default: state_d = S_ERR;
        endcase
      end

      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_src_o = 1'b1;
        mem_we_o   = (opcode == OP_STORE);
        if (mem_ready_i) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            ret_d   = ret_q + CNT_W'(1);
          end
        end else if (wait_limit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_we_o = 1'b1;
        wb_sel_o = (opcode == OP_LOAD);
        state_d  = S_FETCH;
        ret_d    = ret_q + CNT_W'(1);
      end

      S_ERR: begin
        err_o = 1'b1;
      end

      default: state_d = S_ERR;
    endcase
  end

  assign state_o   = state_q;
  assign retired_o = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase model predicts every cycle's outputs.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam int MAXW = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      instr_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             mem_req_o, mem_we_o, addr_src_o, ir_we_o, pc_we_o, pc_src_o;
  logic             reg_we_o, wb_sel_o, err_o;
  logic [1:0]       alu_src_a_o, alu_src_b_o, alu_op_o, imm_sel_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MAXW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .instr_i(instr_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .addr_src_o(addr_src_o), .ir_we_o(ir_we_o),
    .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .reg_we_o(reg_we_o),
    .wb_sel_o(wb_sel_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .imm_sel_o(imm_sel_o), .state_o(state_o),
    .err_o(err_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  logic [19:0] obs;
  assign obs = {state_o, err_o, mem_req_o, mem_we_o, addr_src_o, ir_we_o, pc_we_o,
                pc_src_o, reg_we_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o, imm_sel_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // Expected output vector for a phase; error flag is implied by the ERR state
  function automatic logic [19:0] ev(input logic [2:0] st, input logic req, input logic we,
                                     input logic asrc, input logic irwe, input logic pcwe,
                                     input logic pcsrc, input logic regwe, input logic wbsel,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] imm);
    return {st, (st == 3'd6), req, we, asrc, irwe, pcwe, pcsrc, regwe, wbsel, a, b, op, imm};
  endfunction

  function automatic logic [19:0] ev_idle();
    return ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
  endfunction

  function automatic logic [19:0] ev_err();
    return ev(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
  endfunction

  // One clock: apply inputs, compare mid-cycle, advance past the next rising edge
  task automatic step(input string tag, input logic [19:0] want, input logic rdy, input logic z);
    mem_ready_i = rdy;
    zero_i      = z;
    @(negedge clk_i);
    check(tag, 32'(obs), 32'(want));
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1;
    check("rst_outs", 32'(obs), 32'(ev_idle()));
    check("rst_ret", retired_o, 32'd0);
    exp_ret = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b0;
    step("idle_hold", ev_idle(), 1'($urandom), 1'($urandom));
    start_i = 1'b1;
    step("idle_start", ev_idle(), 1'($urandom), 1'($urandom));
    start_i = 1'b0;
  endtask

  // Memory-handshake phase; dly >= MAXW means ready never arrives
  task automatic mem_phase(input bit is_fetch, input bit is_sw, input int dly, output bit timed_out);
    logic rdy;
    timed_out = (dly >= MAXW);
    for (int i = 0; i < MAXW; i++) begin
      rdy = (i == dly);
      if (is_fetch)
        step("fetch", ev(3'd1, 1, 0, 0, rdy, rdy, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0), rdy, 1'($urandom));
      else
        step("mem", ev(3'd4, 1, is_sw, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0), rdy, 1'($urandom));
      if (rdy) break;
    end
  endtask

  task automatic err_hold(input int n);
    for (int i = 0; i < n; i++) begin
      start_i = 1'($urandom);
      step("err_hold", ev_err(), 1'($urandom), 1'($urandom));
    end
    start_i = 1'b0;
    check("err_ret", retired_o, 32'(exp_ret));
  endtask

  // kind: 0=R 1=I-ALU 2=lw 3=sw 4=beq 5=illegal
  task automatic run_instr(input int kind, input logic [31:0] ins, input int fd, input int md,
                           input logic z, output bit err);
    bit to;
    err = 1'b0;
    instr_i = ins;
    mem_phase(1'b1, 1'b0, fd, to);
    if (to) begin err = 1'b1; return; end
    step("decode", ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 2'd2), 1'($urandom), 1'($urandom));
    case (kind)
      0: step("exec_r", ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0), 1'($urandom), 1'($urandom));
      1: step("exec_i", ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd2, 2'd0), 1'($urandom), 1'($urandom));
      2: step("exec_lw", ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 2'd0), 1'($urandom), 1'($urandom));
      3: step("exec_sw", ev(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 2'd1), 1'($urandom), 1'($urandom));
      4: step("exec_beq", ev(3'd3, 0, 0, 0, 0, z, z, 0, 0, 2'd2, 2'd0, 2'd1, 2'd0), 1'($urandom), z);
      default: begin err = 1'b1; return; end
    endcase
    if (kind == 2 || kind == 3) begin
      mem_phase(1'b0, kind == 3, md, to);
      if (to) begin err = 1'b1; return; end
    end
    if (kind != 3 && kind != 4)
      step("wb", ev(3'd5, 0, 0, 0, 0, 0, 0, 1, kind == 2, 2'd0, 2'd0, 2'd0, 2'd0), 1'($urandom), 1'($urandom));
    exp_ret++;
    check("retired", retired_o, 32'(exp_ret));
  endtask

  function automatic logic [31:0] mk_instr(input int kind);
    logic [31:0] w;
    w = $urandom;
    case (kind)
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      default: w[6:0] = 7'b1100011;
    endcase
    return w;
  endfunction

  function automatic int rnd_dly();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    int k;
    rst_i = 1'b1; start_i = 1'b0; instr_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk_i);
    do_reset();
    start_run();

    run_instr(1, 32'h0050_0093, 0, 0, 1'b0, e);
    check("err_addi", 32'(e), 32'd0);
    run_instr(2, 32'h0000_A103, 3, 3, 1'b0, e);
    run_instr(4, mk_instr(4), 0, 0, 1'b1, e);
    run_instr(4, mk_instr(4), 0, 0, 1'b0, e);
    run_instr(3, mk_instr(3), 0, 15, 1'b0, e);
    run_instr(2, mk_instr(2), 15, 0, 1'b0, e);
    check("err_limit_ok", 32'(err_o), 32'd0);

    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 4));
      run_instr(k, mk_instr(k), rnd_dly(), rnd_dly(), 1'($urandom), e);
    end

    // asynchronous reset while a fetch request is outstanding
    mem_ready_i = 1'b0;
    do_reset();
    start_run();

    // memory never ready in MEM
    run_instr(0, mk_instr(0), 1, 0, 1'b0, e);
    run_instr(2, mk_instr(2), 0, MAXW, 1'b0, e);
    check("mem_to_err", 32'(e), 32'd1);
    err_hold(4);
    do_reset();
    start_run();

    // memory never ready in FETCH
    run_instr(1, mk_instr(1), MAXW, 0, 1'b0, e);
    check("fetch_to_err", 32'(e), 32'd1);
    err_hold(3);
    do_reset();
    start_run();

    // illegal opcode
    run_instr(3, mk_instr(3), 0, 0, 1'b0, e);
    run_instr(5, 32'h0000_007F, 0, 0, 1'b0, e);
    err_hold(5);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
